// File: rtl/lenet_layer_sequencer.sv
// Top-level LeNet scheduler: runs six layer engines in order over en/finish handshakes,
// muxes the shared BRAM ports to the active engine and picks the winning class.
module lenet_layer_sequencer #(
    parameter int unsigned NUM_LAYERS     = 6,
    parameter int unsigned NUM_CLASSES    = 10,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned GAP_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [NUM_LAYERS-1:0]      layer_en,
    input  logic [NUM_LAYERS-1:0]      layer_finish,
    input  logic [NUM_LAYERS-1:0]      lyr_bw_ena,
    input  logic [NUM_LAYERS*19-1:0]   lyr_bw_addra,
    input  logic [NUM_LAYERS-1:0]      lyr_res_ena,
    input  logic [NUM_LAYERS-1:0]      lyr_res_wea,
    input  logic [NUM_LAYERS*15-1:0]   lyr_res_addra,
    input  logic [NUM_LAYERS*8-1:0]    lyr_res_dina,
    output logic                       bias_weights_bram_ena,
    output logic [18:0]                bias_weights_bram_addra,
    output logic                       result_bram_ena,
    output logic                       result_bram_wea,
    output logic [14:0]                result_bram_addra,
    output logic [7:0]                 result_bram_dina,
    input  logic [8*NUM_CLASSES-1:0]   fc_scores,
    output logic                       busy,
    output logic [2:0]                 cur_layer,
    output logic                       done,
    output logic                       error,
    output logic [3:0]                 class_id,
    output logic [7:0]                 class_score
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [2:0]               r_layer;
    logic [1:0]               r_settle;
    logic [31:0]              r_wdog;
    logic [31:0]              r_gap;
    logic [3:0]               r_idx;
    logic [8*NUM_CLASSES-1:0] r_scores;
    logic signed [7:0]        r_best;
    logic [3:0]               r_best_idx;
    logic                     r_error;
    logic [3:0]               r_class_id;
    logic [7:0]               r_class_score;

    logic                     w_finish;
    logic                     w_settled;
    logic                     w_timeout;
    logic                     w_gap_last;
    logic                     w_last_layer;
    logic                     w_scan_last;
    logic signed [7:0]        w_score;
    logic                     w_better;

    // Stale finish flags from the previous inference are masked for the first two enabled cycles.
    assign w_finish     = layer_finish[r_layer];
    assign w_settled    = (r_settle == 2'd2);
    assign w_timeout    = ((r_wdog + 32'd1) >= TIMEOUT_CYCLES);
    assign w_gap_last   = (r_gap == (GAP_CYCLES - 1));
    assign w_last_layer = (r_layer == 3'(NUM_LAYERS - 1));
    assign w_scan_last  = (r_idx == 4'(NUM_CLASSES - 1));
    assign w_score      = r_scores[8*NUM_CLASSES-1 -: 8];
    assign w_better     = (w_score > r_best);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_settled && w_finish) w_state_nxt = S_GAP;
                else if (w_timeout)        w_state_nxt = S_IDLE;
            end
            S_GAP: begin
                if (w_gap_last) w_state_nxt = w_last_layer ? S_ARGMAX : S_RUN;
            end
            S_ARGMAX: begin
                if (w_scan_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_layer       <= '0;
            r_settle      <= '0;
            r_wdog        <= '0;
            r_gap         <= '0;
            r_idx         <= '0;
            r_scores      <= '0;
            r_best        <= '0;
            r_best_idx    <= '0;
            r_error       <= 1'b0;
            r_class_id    <= '0;
            r_class_score <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_layer  <= '0;
                        r_error  <= 1'b0;
                        r_settle <= '0;
                        r_wdog   <= '0;
                    end
                end
                S_RUN: begin
                    if (!w_settled) r_settle <= r_settle + 2'd1;
                    r_wdog <= r_wdog + 32'd1;
                    r_gap  <= '0;
                    if (!(w_settled && w_finish) && w_timeout) r_error <= 1'b1;
                end
                S_GAP: begin
                    r_gap <= r_gap + 32'd1;
                    if (w_gap_last) begin
                        if (!w_last_layer) begin
                            r_layer  <= r_layer + 3'd1;
                            r_settle <= '0;
                            r_wdog   <= '0;
                        end else begin
                            r_scores   <= fc_scores;
                            r_best     <= fc_scores[8*NUM_CLASSES-1 -: 8];
                            r_best_idx <= '0;
                            r_idx      <= '0;
                        end
                    end
                end
                S_ARGMAX: begin
                    // Strict greater-than keeps the lowest index on ties.
                    if (w_better) begin
                        r_best     <= w_score;
                        r_best_idx <= r_idx;
                    end
                    r_scores <= r_scores << 8;
                    r_idx    <= r_idx + 4'd1;
                    if (w_scan_last) begin
                        r_class_id    <= w_better ? r_idx : r_best_idx;
                        r_class_score <= w_better ? w_score : r_best;
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        layer_en    = '0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = r_error;
        cur_layer   = r_layer;
        class_id    = r_class_id;
        class_score = r_class_score;
        unique case (r_state)
            S_RUN: begin
                layer_en = NUM_LAYERS'(1) << r_layer;
                busy     = 1'b1;
            end
            S_GAP:    busy = 1'b1;
            S_ARGMAX: busy = 1'b1;
            S_DONE:   done = 1'b1;
            default: begin
            end
        endcase
    end

    // Unregistered on purpose: engines assume a fixed BRAM read turnaround.
    always_comb begin
        bias_weights_bram_ena   = 1'b0;
        bias_weights_bram_addra = '0;
        result_bram_ena         = 1'b0;
        result_bram_wea         = 1'b0;
        result_bram_addra       = '0;
        result_bram_dina        = '0;
        if (r_state == S_RUN) begin
            bias_weights_bram_ena   = lyr_bw_ena[r_layer];
            bias_weights_bram_addra = lyr_bw_addra[19*r_layer +: 19];
            result_bram_ena         = lyr_res_ena[r_layer];
            result_bram_wea         = lyr_res_wea[r_layer];
            result_bram_addra       = lyr_res_addra[15*r_layer +: 15];
            result_bram_dina        = lyr_res_dina[8*r_layer +: 8];
        end
    end

endmodule
